// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, handshaked data-memory access with timeout,
// load/store lane formatting and the MEM/WB register. Buses use big-endian [0:31] numbering.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] storeData_in,
  input  logic [0:31] leapAddr_in,
  input  logic [0:31] nextPC_in,
  input  logic [4:0]  destReg_in,
  input  logic        leap_in,
  input  logic        PCtoReg_in,
  input  logic        RegToPC_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemWrite_in,
  input  logic        loadSign_in,
  input  logic [1:0]  DSize_in,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        leap_out,
  output logic [0:31] leapAddr_out,
  output logic        valid_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        PCtoReg_out,
  output logic [0:31] aluResult_out,
  output logic [0:31] memData_out,
  output logic [0:31] nextPC_out,
  output logic [4:0]  destReg_out,
  output logic        align_err_out,
  output logic        bus_err_out
);

  typedef enum logic {IDLE, WAIT} memState_t;

  function automatic logic isAligned(input logic [0:1] lane, input logic [1:0] size);
    case (size)
      2'b01:   isAligned = ~lane[1];
      2'b10:   isAligned = 1'b1;
      default: isAligned = (lane == 2'b00);
    endcase
  endfunction

  // Returns {wdata, be}; lane 0 is the most significant byte.
  function automatic logic [0:35] storeFormat(input logic [0:31] data, input logic [0:1] lane,
                                              input logic [1:0] size);
    case (size)
      2'b01:   storeFormat = {{2{data[16:31]}}, (lane[0] ? 4'b0011 : 4'b1100)};
      2'b10:   storeFormat = {{4{data[24:31]}}, (4'b1000 >> lane)};
      default: storeFormat = {data, 4'b1111};
    endcase
  endfunction

  function automatic logic [0:31] loadFormat(input logic [0:31] rdata, input logic [0:1] lane,
                                             input logic [1:0] size, input logic sgn);
    logic [0:7]  b;
    logic [0:15] h;
    case (lane)
      2'd0:    b = rdata[0:7];
      2'd1:    b = rdata[8:15];
      2'd2:    b = rdata[16:23];
      default: b = rdata[24:31];
    endcase
    h = lane[0] ? rdata[16:31] : rdata[0:15];
    case (size)
      2'b01:   loadFormat = {{16{sgn & h[0]}}, h};
      2'b10:   loadFormat = {{24{sgn & b[0]}}, b};
      default: loadFormat = rdata;
    endcase
  endfunction

  memState_t        state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;

  logic        vld_p0;
  logic [0:31] aluResult_p0, storeData_p0, leapAddr_p0, nextPC_p0;
  logic [4:0]  destReg_p0;
  logic        leap_p0, pcToReg_p0, regWrite_p0, memToReg_p0, memWrite_p0, loadSign_p0;
  logic [1:0]  dSize_p0;

  logic        memOp, misalign, timeout, accessOk, done, inMemOp;
  logic [0:35] stFmt;
  logic        unusedSink;

  // Jump-register targets arrive already resolved in leapAddr_in.
  assign unusedSink = RegToPC_in;

  assign memOp     = vld_p0 & (memToReg_p0 | memWrite_p0);
  assign misalign  = memOp & ~isAligned(aluResult_p0[30:31], dSize_p0);
  assign timeout   = (state == WAIT) & ~dmem_ready & (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign accessOk  = (state == WAIT) & dmem_ready;
  assign stall_out = (state == WAIT) & ~dmem_ready & ~timeout;
  assign done      = vld_p0 & ~stall_out;
  assign inMemOp   = valid_in & ~flush_in & (MemToReg_in | MemWrite_in)
                   & isAligned(aluResult_in[30:31], DSize_in);

  always_comb begin
    stateNext   = state;
    waitCntNext = '0;
    if (stall_out) waitCntNext = waitCnt + CNT_W'(1);
    else           stateNext   = inMemOp ? WAIT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // EX/MEM boundary (p0)
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0       <= 1'b0;
      aluResult_p0 <= '0;
      storeData_p0 <= '0;
      leapAddr_p0  <= '0;
      nextPC_p0    <= '0;
      destReg_p0   <= '0;
      leap_p0      <= 1'b0;
      pcToReg_p0   <= 1'b0;
      regWrite_p0  <= 1'b0;
      memToReg_p0  <= 1'b0;
      memWrite_p0  <= 1'b0;
      loadSign_p0  <= 1'b0;
      dSize_p0     <= '0;
    end else if (!stall_out) begin
      vld_p0       <= valid_in & ~flush_in;
      aluResult_p0 <= aluResult_in;
      storeData_p0 <= storeData_in;
      leapAddr_p0  <= leapAddr_in;
      nextPC_p0    <= nextPC_in;
      destReg_p0   <= destReg_in;
      leap_p0      <= leap_in;
      pcToReg_p0   <= PCtoReg_in;
      regWrite_p0  <= RegWrite_in;
      memToReg_p0  <= MemToReg_in;
      memWrite_p0  <= MemWrite_in;
      loadSign_p0  <= loadSign_in;
      dSize_p0     <= DSize_in;
    end
  end

  assign stFmt        = storeFormat(storeData_p0, aluResult_p0[30:31], dSize_p0);
  assign dmem_req     = (state == WAIT);
  assign dmem_we      = dmem_req & memWrite_p0;
  assign dmem_addr    = {aluResult_p0[0:29], 2'b00};
  assign dmem_wdata   = stFmt[0:31];
  assign dmem_be      = dmem_req ? stFmt[32:35] : 4'b0000;
  assign leap_out     = leap_p0 & vld_p0;
  assign leapAddr_out = leapAddr_p0;

  // MEM/WB boundary (p1): error completions never write the register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out     <= 1'b0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      PCtoReg_out   <= 1'b0;
      aluResult_out <= '0;
      memData_out   <= '0;
      nextPC_out    <= '0;
      destReg_out   <= '0;
      align_err_out <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      valid_out     <= done;
      RegWrite_out  <= done & regWrite_p0 & ~misalign & ~timeout;
      align_err_out <= done & misalign;
      bus_err_out   <= timeout;
      if (done) begin
        MemToReg_out  <= memToReg_p0;
        PCtoReg_out   <= pcToReg_p0;
        aluResult_out <= aluResult_p0;
        nextPC_out    <= nextPC_p0;
        destReg_out   <= destReg_p0;
        memData_out   <= (accessOk & memToReg_p0)
                       ? loadFormat(dmem_rdata, aluResult_p0[30:31], dSize_p0, loadSign_p0)
                       : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops, a scripted memory responder,
// and a monitor that checks every MEM/WB result against the expected queue.
module tb_mem_stage;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, flush_in;
  logic [0:31] aluResult_in, storeData_in, leapAddr_in, nextPC_in;
  logic [4:0]  destReg_in;
  logic        leap_in, PCtoReg_in, RegToPC_in, RegWrite_in, MemToReg_in, MemWrite_in, loadSign_in;
  logic [1:0]  DSize_in;
  logic [0:31] dmem_addr, dmem_wdata, dmem_rdata;
  logic [0:3]  dmem_be;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        stall_out, leap_out;
  logic [0:31] leapAddr_out;
  logic        valid_out, RegWrite_out, MemToReg_out, PCtoReg_out;
  logic [0:31] aluResult_out, memData_out, nextPC_out;
  logic [4:0]  destReg_out;
  logic        align_err_out, bus_err_out;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush_in(flush_in),
    .aluResult_in(aluResult_in), .storeData_in(storeData_in), .leapAddr_in(leapAddr_in),
    .nextPC_in(nextPC_in), .destReg_in(destReg_in), .leap_in(leap_in), .PCtoReg_in(PCtoReg_in),
    .RegToPC_in(RegToPC_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemWrite_in(MemWrite_in), .loadSign_in(loadSign_in), .DSize_in(DSize_in),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .leap_out(leap_out), .leapAddr_out(leapAddr_out),
    .valid_out(valid_out), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .PCtoReg_out(PCtoReg_out), .aluResult_out(aluResult_out), .memData_out(memData_out),
    .nextPC_out(nextPC_out), .destReg_out(destReg_out),
    .align_err_out(align_err_out), .bus_err_out(bus_err_out)
  );

  typedef struct {
    logic v, fl;
    logic [0:31] alu, sd, la, npc;
    logic [4:0] rd;
    logic leap, pc2r, r2pc, rw, m2r, mw, ls;
    logic [1:0] sz;
  } op_t;

  typedef struct {
    logic [0:31] alu, mem, npc;
    logic [4:0] rd;
    logic rw, m2r, pc2r, aerr, berr;
  } wb_t;

  typedef struct {
    int delay;
    logic [0:31] data;
  } resp_t;

  wb_t   expQ[$];
  resp_t respQ[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic op_t nop();
    op_t o;
    o = '{default: '0};
    return o;
  endfunction

  function automatic op_t mkOp(logic [0:31] alu, logic [1:0] sz, logic m2r, logic mw, logic rw,
                               logic ls, logic [0:31] sd, logic [4:0] rd);
    op_t o;
    o = nop();
    o.v = 1'b1; o.alu = alu; o.sz = sz; o.m2r = m2r; o.mw = mw; o.rw = rw;
    o.ls = ls; o.sd = sd; o.rd = rd; o.npc = 32'h0001_0000 | alu;
    return o;
  endfunction

  task automatic expWb(input op_t o, input logic [0:31] mem, input logic rw,
                       input logic aerr, input logic berr);
    wb_t e;
    e.alu = o.alu; e.mem = mem; e.npc = o.npc; e.rd = o.rd; e.rw = rw;
    e.m2r = o.m2r; e.pc2r = o.pc2r; e.aerr = aerr; e.berr = berr;
    expQ.push_back(e);
  endtask

  task automatic resp(input int delay, input logic [0:31] data);
    resp_t r;
    r.delay = delay; r.data = data;
    respQ.push_back(r);
  endtask

  task automatic driveOp(input op_t o);
    valid_in = o.v; flush_in = o.fl; aluResult_in = o.alu; storeData_in = o.sd;
    leapAddr_in = o.la; nextPC_in = o.npc; destReg_in = o.rd; leap_in = o.leap;
    PCtoReg_in = o.pc2r; RegToPC_in = o.r2pc; RegWrite_in = o.rw; MemToReg_in = o.m2r;
    MemWrite_in = o.mw; loadSign_in = o.ls; DSize_in = o.sz;
  endtask

  // Present an op and hold it until the stage accepts it; returns stall cycles seen.
  task automatic sendOp(input op_t o, output int stalls);
    logic s;
    bit   ok;
    driveOp(o);
    stalls = 0; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); s = stall_out;
      @(posedge clk); #1;
      if (!s) ok = 1; else stalls++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_bound: stall_out still 1 after 100 cycles, expected 0");
    end
    driveOp(nop());
  endtask

  task automatic drain(output int stalls);
    bit ok;
    stalls = 0; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!stall_out) ok = 1; else stalls++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_bound: stall_out still 1 after 100 cycles, expected 0");
    end
  endtask

  task automatic checkZero(input string p);
    chk({p, "_addr"}, dmem_addr, 32'h0);
    chk({p, "_wdata"}, dmem_wdata, 32'h0);
    chk({p, "_ctl"}, 32'({dmem_be, dmem_req, dmem_we, stall_out, leap_out, valid_out, RegWrite_out,
                          MemToReg_out, PCtoReg_out, align_err_out, bus_err_out}), 32'h0);
    chk({p, "_wbdata"}, aluResult_out | memData_out | nextPC_out | leapAddr_out | 32'(destReg_out),
        32'h0);
  endtask

  // Memory responder: one scripted entry per access, ready after 'delay' wait cycles.
  resp_t cur;
  bit    active = 0;
  int    n = 0;
  always @(posedge clk) begin
    #2;
    if (!reset || !dmem_req) begin
      dmem_ready = 1'b0; active = 0; n = 0;
    end else begin
      if (!active) begin
        if (respQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: dmem_req=1 at addr 0x%h with no access expected", dmem_addr);
          cur.delay = NEVER; cur.data = '0;
        end else begin
          cur = respQ.pop_front();
        end
        active = 1; n = 0;
      end
      if (n == cur.delay) begin
        dmem_ready = 1'b1; dmem_rdata = cur.data; active = 0;
      end else begin
        dmem_ready = 1'b0; n++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    wb_t e;
    if (valid_out) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wb: valid_out=1 alu=0x%h, expected no result", aluResult_out);
      end else begin
        e = expQ.pop_front();
        chk("wb_alu", aluResult_out, e.alu);
        chk("wb_mem", memData_out, e.mem);
        chk("wb_npc", nextPC_out, e.npc);
        chk("wb_ctl", 32'({destReg_out, RegWrite_out, MemToReg_out, PCtoReg_out, align_err_out,
                           bus_err_out}),
            32'({e.rd, e.rw, e.m2r, e.pc2r, e.aerr, e.berr}));
      end
    end else begin
      chk("idle_flags", 32'({RegWrite_out, align_err_out, bus_err_out}), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o, o2;
    int  s, st;
    dmem_ready = 1'b0; dmem_rdata = '0;
    reset = 1'b0;
    driveOp(nop());
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // word load, ready after 3 wait cycles
    o = mkOp(32'h100, 2'b00, 1, 0, 1, 0, 0, 5'd5);
    resp(3, 32'hDEADBEEF); expWb(o, 32'hDEADBEEF, 1, 0, 0);
    sendOp(o, s); drain(st);
    chk("ld_word_stall", st, 3);

    // byte / half loads, signed and unsigned
    o = mkOp(32'h103, 2'b10, 1, 0, 1, 1, 0, 5'd6);
    resp(1, 32'h000000F0); expWb(o, 32'hFFFFFFF0, 1, 0, 0);
    sendOp(o, s); drain(st);
    chk("ld_byte_stall", st, 1);
    o = mkOp(32'h103, 2'b10, 1, 0, 1, 0, 0, 5'd7);
    resp(0, 32'h000000F0); expWb(o, 32'h000000F0, 1, 0, 0);
    sendOp(o, s); drain(st);
    o = mkOp(32'h102, 2'b01, 1, 0, 1, 1, 0, 5'd8);
    resp(0, 32'h12348001); expWb(o, 32'hFFFF8001, 1, 0, 0);
    sendOp(o, s); drain(st);
    o = mkOp(32'h100, 2'b10, 1, 0, 1, 0, 0, 5'd9);
    resp(2, 32'h80000000); expWb(o, 32'h00000080, 1, 0, 0);
    sendOp(o, s); drain(st);

    // half store to 0x202
    o = mkOp(32'h202, 2'b01, 0, 1, 0, 0, 32'h1234ABCD, 5'd0);
    resp(1, 32'h0); expWb(o, 32'h0, 0, 0, 0);
    sendOp(o, s);
    @(negedge clk);
    chk("sth_req", 32'({dmem_req, dmem_we}), 32'h3);
    chk("sth_addr", dmem_addr, 32'h200);
    chk("sth_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sth_be", 32'(dmem_be), 32'h3);
    drain(st);

    // byte store to 0x101
    o = mkOp(32'h101, 2'b10, 0, 1, 0, 0, 32'h000000A5, 5'd0);
    resp(1, 32'h0); expWb(o, 32'h0, 0, 0, 0);
    sendOp(o, s);
    @(negedge clk);
    chk("stb_addr", dmem_addr, 32'h100);
    chk("stb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("stb_be", 32'(dmem_be), 32'h4);
    drain(st);

    // misaligned word and half loads
    o = mkOp(32'h101, 2'b00, 1, 0, 1, 0, 0, 5'd10);
    expWb(o, 32'h0, 0, 1, 0);
    sendOp(o, s);
    @(negedge clk);
    chk("misal_word_noreq", 32'({dmem_req, stall_out}), 32'h0);
    drain(st);
    o = mkOp(32'h103, 2'b01, 1, 0, 1, 1, 0, 5'd11);
    expWb(o, 32'h0, 0, 1, 0);
    sendOp(o, s); drain(st);
    chk("misal_half_stall", st, 0);

    // timeout, then pipeline resumes
    o = mkOp(32'h300, 2'b00, 1, 0, 1, 0, 0, 5'd12);
    resp(NEVER, 32'h0); expWb(o, 32'h0, 0, 0, 1);
    sendOp(o, s); drain(st);
    chk("timeout_stall", st, TO - 1);
    o = mkOp(32'h77, 2'b00, 0, 0, 1, 0, 0, 5'd13);
    expWb(o, 32'h0, 1, 0, 0);
    sendOp(o, s); drain(st);

    // back-to-back: load ready immediately, then an ALU op
    o  = mkOp(32'h104, 2'b00, 1, 0, 1, 0, 0, 5'd14);
    o2 = mkOp(32'h55, 2'b00, 0, 0, 1, 0, 0, 5'd7);
    resp(0, 32'hCAFEF00D); expWb(o, 32'hCAFEF00D, 1, 0, 0); expWb(o2, 32'h0, 1, 0, 0);
    sendOp(o, s); sendOp(o2, s);
    chk("b2b_stall", s, 0);
    @(negedge clk); chk("b2b_valid1", 32'(valid_out), 32'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_valid2", 32'(valid_out), 32'h1);
    @(posedge clk); #1;

    // flushed load produces nothing
    o = mkOp(32'h400, 2'b00, 1, 0, 1, 0, 0, 5'd3);
    o.fl = 1'b1;
    sendOp(o, s);
    @(negedge clk); chk("flush_noreq", 32'(dmem_req), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("flush_novalid", 32'(valid_out), 32'h0);
    @(posedge clk); #1;

    // branch redirect for exactly one cycle
    o = mkOp(32'h0, 2'b00, 0, 0, 0, 0, 0, 5'd0);
    o.leap = 1'b1; o.la = 32'h4000;
    expWb(o, 32'h0, 0, 0, 0);
    sendOp(o, s);
    @(negedge clk);
    chk("leap_on", 32'(leap_out), 32'h1);
    chk("leap_addr", leapAddr_out, 32'h4000);
    @(posedge clk); #1;
    @(negedge clk); chk("leap_off", 32'(leap_out), 32'h0);
    @(posedge clk); #1;

    // link write
    o = mkOp(32'h20, 2'b00, 0, 0, 1, 0, 0, 5'd31);
    o.pc2r = 1'b1; o.npc = 32'h108; o.leap = 1'b1; o.la = 32'h800;
    expWb(o, 32'h0, 1, 0, 0);
    sendOp(o, s); drain(st);

    // reset in the middle of an access
    o = mkOp(32'h500, 2'b00, 1, 0, 1, 0, 0, 5'd4);
    resp(NEVER, 32'h0);
    sendOp(o, s);
    reset = 1'b0;
    @(negedge clk); chk("midrst_req_before", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    @(negedge clk); checkZero("midrst");
    respQ.delete();
    @(posedge clk); #1;
    reset = 1'b1;

    o = mkOp(32'h88, 2'b00, 0, 0, 1, 0, 0, 5'd2);
    expWb(o, 32'h0, 1, 0, 0);
    sendOp(o, s); drain(st);

    repeat (3) @(posedge clk);
    #1;
    chk("expq_empty", expQ.size(), 0);
    chk("respq_empty", respQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
